// File: rtl/line_refill_arbiter.sv
// Shares one line-wide memory read port between the I- and D-cache refill paths:
// round-robin grant, one outstanding transaction, response-timeout watchdog.
module line_refill_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BITS      = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_BITS-1:0]  i_data,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic [LINE_BITS-1:0]  d_data,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [LINE_BITS-1:0]  mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  timeout_err
);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    tmo_q, tmo_d;
    logic [LINE_BITS-1:0]    i_data_q, i_data_d;
    logic [LINE_BITS-1:0]    d_data_q, d_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= PORT_D;
            grant_q      <= PORT_I;
            addr_q       <= '0;
            timer_q      <= '0;
            tmo_q        <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            timer_q      <= timer_d;
            tmo_q        <= tmo_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        timer_d      = timer_q;
        tmo_d        = tmo_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that did not win last time is served.
                    grant_d      = (i_req && d_req) ? ~last_grant_q : d_req;
                    addr_d       = (grant_d == PORT_D) ? d_addr : i_addr;
                    last_grant_d = grant_d;
                    tmo_d        = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (grant_q == PORT_D) d_data_d = mem_rdata;
                    else                   i_data_d = mem_rdata;
                    state_d = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    // Expiry: the requester still gets its done pulse, with a zero line.
                    if (grant_q == PORT_D) d_data_d = '0;
                    else                   i_data_d = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
                end
            end
            S_RESP: begin
                tmo_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = (state_q == S_ISSUE);
        mem_addr    = (state_q == S_ISSUE) ? (addr_q & LINE_MASK) : '0;
        i_valid     = (state_q == S_RESP) && (grant_q == PORT_I);
        d_valid     = (state_q == S_RESP) && (grant_q == PORT_D);
        timeout_err = (state_q == S_RESP) && tmo_q;
        i_data      = i_data_q;
        d_data      = d_data_q;
    end

endmodule

// File: tb/tb_line_refill_arbiter.sv
// Randomised scoreboard bench for line_refill_arbiter: a memory responder predicts each
// refill's port, line and completion cycle; a monitor checks every valid pulse against it.
module tb_line_refill_arbiter;
    localparam int TMO = 8;
    localparam logic [31:0] KEEP = 32'hFFFF_FFC0;

    logic         clk, rst;
    logic         i_req, d_req, i_valid, d_valid;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic [511:0] i_data, d_data, mem_rdata;
    logic         mem_req, mem_ack, mem_rvalid, timeout_err;

    line_refill_arbiter #(.ADDR_WIDTH(32), .LINE_BITS(512), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
        .d_req(d_req), .d_addr(d_addr), .d_data(d_data), .d_valid(d_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .timeout_err(timeout_err)
    );

    typedef struct {
        int           port;
        logic [511:0] data;
        bit           tmo;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_grant = 1;
    int   ack_dly_fix = -1;
    int   rv_dly_fix = -1;
    bit   use_a5 = 0;
    logic hist_i = 0, hist_d = 0;
    logic [31:0] hist_ia = '0, hist_da = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Request state the DUT samples at the end of this cycle, kept for one cycle.
    always @(negedge clk) begin
        hist_i  <= i_req;
        hist_d  <= d_req;
        hist_ia <= i_addr;
        hist_da <= d_addr;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Memory responder and grant model.
    initial begin : responder
        int           port, n, d, a;
        logic [31:0]  exp_addr;
        logic [511:0] line;
        exp_t         e;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        forever begin
            if (!mem_req) begin
                @(negedge clk);
                continue;
            end
            chk("grant_source", hist_i | hist_d, 1);
            if (hist_i && hist_d) port = (last_grant == 1) ? 0 : 1;
            else                  port = hist_d ? 1 : 0;
            last_grant = port;
            exp_addr = (port == 1 ? hist_da : hist_ia) & KEEP;
            chk("mem_addr", mem_addr, exp_addr);
            n = (ack_dly_fix >= 0) ? ack_dly_fix
                                   : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            repeat (n) begin
                @(negedge clk);
                chk("req_held", mem_req, 1);
                chk("addr_held", mem_addr, exp_addr);
            end
            mem_ack = 1;
            a = cyc;
            @(negedge clk);
            mem_ack = 0;
            if (rv_dly_fix == -2) continue;
            d = (rv_dly_fix >= 1) ? rv_dly_fix
                                  : (($urandom_range(0, 7) == 0) ? $urandom_range(8, 9) : $urandom_range(1, 7));
            line = use_a5 ? {64{8'hA5}} : rand_line();
            e.port = port;
            if (d <= TMO - 1) begin
                e.data = line; e.tmo = 0; e.cyc = a + d + 1;
            end else begin
                e.data = '0; e.tmo = 1; e.cyc = a + TMO;
            end
            sbq.push_back(e);
            repeat (d - 1) @(negedge clk);
            mem_rvalid = 1;
            mem_rdata  = line;
            @(negedge clk);
            mem_rvalid = 0;
        end
    end

    // Completion monitor.
    initial begin : monitor
        exp_t         e;
        int           act_port;
        logic [511:0] act_data;
        forever begin
            @(negedge clk);
            if (i_valid || d_valid || timeout_err) begin
                act_port = i_valid ? (d_valid ? 3 : 0) : (d_valid ? 1 : 2);
                act_data = d_valid ? d_data : i_data;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected port %0d tmo %0b at cycle %0d, none expected",
                             act_port, timeout_err, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_port", act_port, e.port);
                    chk("sb_data", act_data, e.data);
                    chk("sb_timeout_err", timeout_err, e.tmo);
                    chk("sb_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic raise_req(input int port, input logic [31:0] addr);
        @(posedge clk); #1;
        if (port == 0) begin i_addr = addr; i_req = 1; end
        else           begin d_addr = addr; d_req = 1; end
    endtask

    task automatic raise_both(input logic [31:0] ia, input logic [31:0] da);
        @(posedge clk); #1;
        i_addr = ia; d_addr = da; i_req = 1; d_req = 1;
    endtask

    // Waits for the port's done pulse, then drops its request in the following cycle.
    task automatic wait_valid(input int port, input int budget, output int got);
        bit found = 0;
        got = -1;
        for (int t = 0; t < budget && !found; t++) begin
            @(negedge clk);
            if ((port == 0 && i_valid) || (port == 1 && d_valid)) begin
                found = 1;
                got = cyc;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL valid_wait port %0d got none expected pulse within %0d cycles", port, budget);
        end
        @(posedge clk); #1;
        if (port == 0) i_req = 0; else d_req = 0;
    endtask

    task automatic rand_requester(input int port, input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            repeat (1 + $urandom_range(0, 5)) @(posedge clk);
            #1;
            if (port == 0) begin i_addr = $urandom; i_req = 1; end
            else           begin d_addr = $urandom; d_req = 1; end
            wait_valid(port, 400, g);
            if (port == 0) i_addr = $urandom; else d_addr = $urandom;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1;
        last_grant = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_i_valid"}, i_valid, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_i_data"}, i_data, 0);
        chk({tag, "_d_data"}, d_data, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout got no finish expected finish before 400000ns");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int  r1, r2, r3, r4;
        bit  seen;
        rst = 1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 0;

        // I-only refill with a fixed pattern, ack immediately, data two cycles later.
        ack_dly_fix = 0; rv_dly_fix = 2; use_a5 = 1;
        raise_req(0, 32'h0000_1040);
        @(negedge clk);
        chk("t1_req_not_yet", mem_req, 0);
        @(negedge clk);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1040);
        wait_valid(0, 20, r1);
        chk("t1_i_data", i_data, {64{8'hA5}});
        chk("t1_d_data", d_data, 0);
        use_a5 = 0; rv_dly_fix = -1; ack_dly_fix = -1;

        // Tie after reset goes to I, then D; after an I-only grant a tie goes to D.
        pulse_reset();
        raise_both(32'h2000_0000, 32'h3000_0040);
        wait_valid(0, 60, r1);
        wait_valid(1, 60, r2);
        chk("t2_order_id", r2 > r1, 1);
        raise_req(0, 32'h2000_1000);
        wait_valid(0, 60, r1);
        raise_both(32'h2000_2000, 32'h3000_2000);
        wait_valid(1, 60, r3);
        wait_valid(0, 60, r4);
        chk("t2_order_di", r4 > r3, 1);

        // D rises while I waits for data: D is issued right after I completes.
        ack_dly_fix = 0; rv_dly_fix = 4;
        raise_req(0, 32'h4000_0080);
        repeat (3) @(posedge clk);
        #1;
        d_addr = 32'h5000_00FF; d_req = 1;
        wait_valid(0, 40, r1);
        @(negedge clk);
        chk("t3_idle_gap", mem_req, 0);
        @(negedge clk);
        chk("t3_d_issue", mem_req, 1);
        chk("t3_d_addr", mem_addr, 32'h5000_00C0);
        wait_valid(1, 40, r2);

        // Long ack stall: request stays up, no watchdog in the issue phase.
        ack_dly_fix = 20; rv_dly_fix = 3;
        raise_req(1, 32'h6000_0100);
        wait_valid(1, 60, r1);

        // Response timeout, late rvalid in RESP and in IDLE, then a normal refill.
        ack_dly_fix = 0; rv_dly_fix = 8;
        raise_req(0, 32'h7000_0000);
        wait_valid(0, 40, r1);
        rv_dly_fix = 9;
        raise_req(1, 32'h7000_0400);
        wait_valid(1, 40, r1);
        rv_dly_fix = 3;
        raise_req(0, 32'h7000_0800);
        wait_valid(0, 40, r1);

        // Asynchronous reset while waiting for data; held requests restart with I first.
        ack_dly_fix = 0; rv_dly_fix = -2;
        raise_both(32'h8000_0000, 32'h9000_0000);
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        chk("t6_issue_seen", seen, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        last_grant = 1;
        #1;
        chk_all_zero("t6_async");
        rv_dly_fix = -1; ack_dly_fix = -1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        wait_valid(0, 60, r1);
        wait_valid(1, 60, r2);
        chk("t6_order_id", r2 > r1, 1);

        // Randomised traffic from both caches.
        fork
            rand_requester(0, 25);
            rand_requester(1, 25);
        join
        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
